// File: rtl/div_pkg.sv
// div_pkg: shared state enum, default width and counter sizing for seq_udiv
package div_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
  localparam int DIV_W_DEFAULT = 8;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step
module div_step #(
  parameter int W = 8
) (
  input  logic [W:0]   r,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   r_next,
  output logic         q_bit
);
  logic [W+1:0] wide;
  logic [W:0]   diff;
  always_comb begin
    wide   = {r, bit_in};
    diff   = wide[W:0] - {1'b0, divisor};
    q_bit  = wide >= {2'b0, divisor};
    r_next = q_bit ? diff : wide[W:0];
  end
endmodule

// File: rtl/seq_udiv.sv
// seq_udiv: multi-cycle unsigned restoring divider, one quotient bit per clock
module seq_udiv
  import div_pkg::*;
#(
  parameter int W = DIV_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = cnt_width(W);
  div_state_t    state, state_n;
  logic [CW-1:0] cnt;
  logic [W:0]    rem, rem_n;
  logic [W-1:0]  dvd, dvs, quo;
  logic          dbz, q_bit, accept, zero;
  div_step #(.W(W)) u_step (
    .r      (rem),
    .bit_in (dvd[W-1]),
    .divisor(dvs),
    .r_next (rem_n),
    .q_bit  (q_bit)
  );
  always_comb begin
    in_ready    = state == IDLE;
    out_valid   = state == DONE;
    accept      = in_valid && in_ready;
    zero        = divisor == '0;
    quotient    = quo;
    remainder   = rem[W-1:0];
    div_by_zero = dbz;
    state_n     = accept ? (zero ? DONE : BUSY)
                : (state == BUSY && cnt == CW'(1)) ? DONE
                : (out_valid && out_ready) ? IDLE
                : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      quo   <= '0;
      dbz   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt <= zero ? '0 : CW'(W);
        rem <= zero ? {1'b0, dividend} : '0;
        quo <= zero ? '1 : '0;
        dbz <= zero;
        dvd <= dividend;
        dvs <= divisor;
      end else if (state == BUSY) begin
        cnt <= cnt - CW'(1);
        rem <= rem_n;
        quo <= {quo[W-2:0], q_bit};
        dvd <= {dvd[W-2:0], 1'b0};
      end
    end
  end
endmodule

// File: tb/tb_seq_udiv.sv
// tb_seq_udiv: directed and randomized checks of seq_udiv against an arithmetic model
module tb_seq_udiv;
  localparam int W = 8;
  localparam int N = 1000;
  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_udiv #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_q(input int unsigned a, input int unsigned b);
    return b == 0 ? (1 << W) - 1 : a / b;
  endfunction

  function automatic int unsigned ref_r(input int unsigned a, input int unsigned b);
    return b == 0 ? a : a % b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int unsigned a, input int unsigned b, input int lat, input int hold);
    int n;
    dividend = W'(a);
    divisor  = W'(b);
    in_valid = 1'b1;
    out_ready = 1'b0;
    chk("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    dividend = '1;
    divisor  = '1;
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("latency", n, lat);
    chk("quotient", quotient, ref_q(a, b));
    chk("remainder", remainder, ref_r(a, b));
    chk("div_by_zero", div_by_zero, b == 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_quotient", quotient, ref_q(a, b));
      chk("hold_remainder", remainder, ref_r(a, b));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_ready", in_ready, 1);
    chk("idle_valid", out_valid, 0);
  endtask

  initial begin
    int unsigned qa[$], qb[$];
    int sent, got, last, cyc;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    tick();

    run_op(200, 7, W + 1, 0);
    run_op(9, 3, W + 1, 0);
    run_op(255, 1, W + 1, 0);
    run_op(0, 5, W + 1, 0);
    run_op(5, 200, W + 1, 0);
    run_op(45, 0, 1, 0);
    run_op(100, 9, W + 1, 5);

    dividend = 8'd250;
    divisor = 8'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    repeat (W + 2) tick();
    chk("abort_no_result", out_valid, 0);
    run_op(250, 3, W + 1, 0);

    for (int i = 0; i < N; i++) begin
      qa.push_back($urandom_range(0, 255));
      qb.push_back($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 255));
    end
    qb[0] = 0;
    qb[1] = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    dividend = W'(qa[0]);
    divisor = W'(qb[0]);
    sent = 1;
    got = 0;
    last = 0;
    cyc = 0;
    while (got < N && cyc < N * 12) begin
      tick();
      cyc++;
      if (out_valid) begin
        chk("b2b_quotient", quotient, ref_q(qa[got], qb[got]));
        chk("b2b_remainder", remainder, ref_r(qa[got], qb[got]));
        chk("b2b_dbz", div_by_zero, qb[got] == 0);
        if (got > 0) chk("b2b_spacing", cyc - last, qb[got] == 0 ? 2 : W + 2);
        last = cyc;
        got++;
      end
      if (in_ready) begin
        if (sent < N) begin
          dividend = W'(qa[sent]);
          divisor = W'(qb[sent]);
          sent++;
        end else in_valid = 1'b0;
      end
    end
    chk("b2b_count", got, N);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
